prime_query_arbiter: RTL and testbench

- Shares one prime-search engine among N_REQ requesters.
- The engine takes an intake value and returns the smallest prime above it and the largest prime below it.
- The block grants requesters round-robin and range-checks each query.
- It issues the query to the engine, waits with a timeout, and returns the result tagged with the requester ID.
- It sits between requester logic and the single engine instance.

---
 rtl/prime_pkg.sv | 32 +++
 rtl/prime_query_arbiter_rr_arbiter.sv | 44 ++++
 rtl/prime_query_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_prime_query_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prime_pkg.sv
// Shared types and limits for the prime-query arbiter and its round-robin sub-block.
package prime_pkg;

  localparam int DATA_W     = 14;
  localparam int MIN_INTAKE = 3;
  localparam int MAX_INTAKE = 9972;
  localparam int ID_MAX_W   = 3;

  localparam logic [DATA_W-1:0] MIN_V = MIN_INTAKE[DATA_W-1:0];
  localparam logic [DATA_W-1:0] MAX_V = MAX_INTAKE[DATA_W-1:0];

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT_LOW,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [DATA_W-1:0]   up;
    logic [DATA_W-1:0]   low;
    logic                err;
  } resp_t;

  function automatic logic in_range(input logic [DATA_W-1:0] v);
    return (v >= MIN_V) && (v <= MAX_V);
  endfunction

endpackage

// File: rtl/prime_query_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant, first set request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             adv,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0]   ptr;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  // Rotate so bit 0 is the pointer position; the lowest set bit is the winner.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N_REQ-1:0];
    any = |rot;
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W+1)'(N_REQ)) idx = IDX_W'(sum - (IDX_W+1)'(N_REQ));
    else                          idx = sum[IDX_W-1:0];
    grant = any ? (N_REQ'(1) << idx) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (adv && any) begin
      ptr <= (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/prime_query_arbiter.sv
// prime_query_arbiter: shares one prime-search engine among N_REQ requesters with timeout.
// Optional one-entry result cache is enabled by defining PRIME_QUERY_CACHE_EN.
module prime_query_arbiter
  import prime_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DATA_W-1:0]  req_intake,
  output logic [N_REQ-1:0]         ack,
  output logic                     resp_valid,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [DATA_W-1:0]        resp_up,
  output logic [DATA_W-1:0]        resp_low,
  output logic                     resp_err,
  output logic                     eng_give_valid,
  output logic [DATA_W-1:0]        eng_intake,
  input  logic [DATA_W-1:0]        eng_up,
  input  logic [DATA_W-1:0]        eng_low,
  input  logic                     eng_out_valid,
  output logic                     eng_restart,
  output logic                     busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO = TIMEOUT_CYC[CNT_W-1:0];

  state_t            state_q, state_d;
  resp_t             resp_q, resp_d;
  logic [DATA_W-1:0] intake_q, intake_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              tmo_q, tmo_d;
  logic              tmo_hit, done_hit;

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;
  logic [DATA_W-1:0] intake_arr [N_REQ];

  logic              cache_hit;
  logic [DATA_W-1:0] cache_up_v, cache_low_v;

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign intake_arr[g] = req_intake[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .adv   (state_q == IDLE),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign cnt_inc  = (cnt_q == TMO) ? cnt_q : cnt_q + CNT_W'(1);
  assign tmo_hit  = (cnt_inc == TMO);
  assign done_hit = (state_q == WAIT) && eng_out_valid;

`ifdef PRIME_QUERY_CACHE_EN
  logic              cache_vld;
  logic [DATA_W-1:0] cache_intake, cache_up, cache_low;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cache_vld <= 1'b0;
    end else if (done_hit) begin
      cache_vld <= 1'b1;
    end else if (tmo_d) begin
      cache_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (done_hit) begin
      cache_intake <= intake_q;
      cache_up     <= eng_up;
      cache_low    <= eng_low;
    end
  end

  assign cache_hit   = cache_vld && (intake_q == cache_intake);
  assign cache_up_v  = cache_up;
  assign cache_low_v = cache_low;
`else
  assign cache_hit   = 1'b0;
  assign cache_up_v  = '0;
  assign cache_low_v = '0;
`endif

  always_comb begin
    state_d  = state_q;
    resp_d   = resp_q;
    intake_d = intake_q;
    cnt_d    = cnt_q;
    tmo_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d   = CHECK;
          intake_d  = intake_arr[grant_idx];
          resp_d.id = ID_MAX_W'(grant_idx);
        end
      end
      CHECK: begin
        resp_d.up  = '0;
        resp_d.low = '0;
        resp_d.err = 1'b0;
        if (!in_range(intake_q)) begin
          state_d    = RESP;
          resp_d.err = 1'b1;
        end else if (cache_hit) begin
          state_d    = RESP;
          resp_d.up  = cache_up_v;
          resp_d.low = cache_low_v;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_LOW;
      end
      // A done level still high from the previous query must drop before we listen.
      WAIT_LOW: begin
        cnt_d = cnt_inc;
        if (tmo_hit) begin
          state_d    = RESP;
          resp_d.err = 1'b1;
          tmo_d      = 1'b1;
        end else if (!eng_out_valid) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (eng_out_valid) begin
          state_d    = RESP;
          resp_d.up  = eng_up;
          resp_d.low = eng_low;
        end else if (tmo_hit) begin
          state_d    = RESP;
          resp_d.err = 1'b1;
          tmo_d      = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      intake_q <= '0;
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      intake_q <= intake_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  always_ff @(posedge clk) begin
    resp_q <= resp_d;
  end

  // Response bus is forced to zero outside the RESP cycle.
  assign ack            = ((state_q == IDLE) && reset) ? grant : '0;
  assign resp_valid     = (state_q == RESP);
  assign resp_id        = resp_valid ? resp_q.id[ID_W-1:0] : '0;
  assign resp_up        = resp_valid ? resp_q.up : '0;
  assign resp_low       = resp_valid ? resp_q.low : '0;
  assign resp_err       = resp_valid & resp_q.err;
  assign eng_give_valid = (state_q == ISSUE);
  assign eng_intake     = intake_q;
  assign eng_restart    = tmo_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_prime_query_arbiter.sv
// Directed bench for prime_query_arbiter with a behavioural engine (TIMEOUT_CYC = 50).
module tb_prime_query_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [55:0] req_intake = '0;
  logic [3:0]  ack;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [13:0] resp_up, resp_low;
  logic        resp_err, eng_give_valid, eng_restart, busy;
  logic [13:0] eng_intake;
  logic [13:0] eng_up = '0, eng_low = '0;
  logic        eng_out_valid = 1'b0;

  prime_query_arbiter #(.N_REQ(4), .TIMEOUT_CYC(50)) dut (
    .clk(clk), .reset(rst_n), .req(req), .req_intake(req_intake), .ack(ack),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_up(resp_up), .resp_low(resp_low),
    .resp_err(resp_err), .eng_give_valid(eng_give_valid), .eng_intake(eng_intake),
    .eng_up(eng_up), .eng_low(eng_low), .eng_out_valid(eng_out_valid),
    .eng_restart(eng_restart), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int idx; } ack_rec_t;
  typedef struct { int cyc; int id; int up; int low; int err; } resp_rec_t;
  typedef struct {
    logic [3:0] req; int intake; int lat; int id; int up; int low; int err; int latency; int gives;
  } vec_t;

  ack_rec_t  ack_log[$];
  resp_rec_t resp_log[$];
  vec_t      vecs[8];
  int        cyc = 0, n_cmp = 0, n_bad = 0, n_give = 0, n_rst = 0, g0 = 0, r0 = 0;
  logic [3:0] ack_pend = '0;

  // Behavioural engine: result eng_lat cycles after the query pulse, level held eng_hold cycles.
  int          eng_lat = 20, eng_hold = 3, eng_cd = 0, eng_hold_cnt = 0;
  logic        eng_mute = 1'b0;
  logic [13:0] eng_cap = '0;

  function automatic void lookup(input logic [13:0] x, output logic [13:0] u, output logic [13:0] l);
    case (x)
      14'd10:   begin u = 14'd11;   l = 14'd7;    end
      14'd100:  begin u = 14'd101;  l = 14'd97;   end
      14'd200:  begin u = 14'd211;  l = 14'd199;  end
      14'd3:    begin u = 14'd5;    l = 14'd2;    end
      14'd50:   begin u = 14'd53;   l = 14'd47;   end
      14'd9972: begin u = 14'd9973; l = 14'd9967; end
      default:  begin u = 14'd0;    l = 14'd0;    end
    endcase
  endfunction

  always @(negedge clk) begin
    if (eng_restart) begin
      eng_cd = 0; eng_hold_cnt = 0; eng_out_valid = 1'b0;
    end else begin
      if (eng_out_valid) begin
        if (eng_hold_cnt > 1) eng_hold_cnt--;
        else begin eng_out_valid = 1'b0; eng_hold_cnt = 0; end
      end
      if (eng_give_valid) begin
        eng_cd = eng_lat; eng_cap = eng_intake;
      end else if (eng_cd > 0) begin
        eng_cd--;
        if (eng_cd == 0 && !eng_mute) begin
          lookup(eng_cap, eng_up, eng_low);
          eng_out_valid = 1'b1; eng_hold_cnt = eng_hold;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // One clock: observe at the falling edge, release acked requests just after the rising edge.
  task automatic step();
    ack_rec_t  a;
    resp_rec_t r;
    @(negedge clk);
    if (ack != 4'd0) begin
      a.cyc = cyc; a.idx = oh_idx(ack); ack_log.push_back(a); ack_pend |= ack;
    end
    if (resp_valid) begin
      r.cyc = cyc; r.id = int'(resp_id); r.up = int'(resp_up); r.low = int'(resp_low);
      r.err = int'(resp_err); resp_log.push_back(r);
    end
    if (eng_give_valid) n_give++;
    if (eng_restart) n_rst++;
    @(posedge clk);
    #1;
    cyc++;
    req = req & ~ack_pend;
    ack_pend = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wait_resp(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (resp_log.size() < n && k < budget) begin step(); k++; end
    if (resp_log.size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timed out with %0d responses, wanted %0d", nm, resp_log.size(), n);
    end
  endtask

  task automatic wait_ack(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (ack_log.size() < n && k < budget) begin step(); k++; end
    if (ack_log.size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timed out with %0d acks, wanted %0d", nm, ack_log.size(), n);
    end
  endtask

  task automatic run_one(input logic [3:0] r, input int intake, input int lat);
    logic [13:0] v;
    ack_log.delete(); resp_log.delete();
    g0 = n_give; r0 = n_rst;
    v = intake[13:0];
    req_intake = {4{v}}; eng_lat = lat; req = r;
    wait_resp(1, 200, "run_one_resp");
    idle(10);
  endtask

  task automatic chk_resp(input string nm, input int k, input int id, input int up,
                          input int low, input int err, input int lat);
    if (resp_log.size() > k && ack_log.size() > k) begin
      chk({nm, "_ack"}, ack_log[k].idx, id);
      chk({nm, "_id"},  resp_log[k].id, id);
      chk({nm, "_up"},  resp_log[k].up, up);
      chk({nm, "_low"}, resp_log[k].low, low);
      chk({nm, "_err"}, resp_log[k].err, err);
      chk({nm, "_lat"}, resp_log[k].cyc - ack_log[k].cyc, lat);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cached_lat;
    logic [13:0] v;
    vecs[0] = '{4'b0001, 10,    20, 0, 11,   7,    0, 23, 1};
    vecs[1] = '{4'b0010, 2,     5,  1, 0,    0,    1, 2,  0};
    vecs[2] = '{4'b0100, 9973,  5,  2, 0,    0,    1, 2,  0};
    vecs[3] = '{4'b1000, 3,     5,  3, 5,    2,    0, 8,  1};
    vecs[4] = '{4'b0010, 9972,  7,  1, 9973, 9967, 0, 10, 1};
    vecs[5] = '{4'b0100, 0,     5,  2, 0,    0,    1, 2,  0};
    vecs[6] = '{4'b0001, 16383, 5,  0, 0,    0,    1, 2,  0};
    vecs[7] = '{4'b1000, 50,    5,  3, 53,   47,   0, 8,  1};

    // Reset with requests pending: everything stays quiet.
    v = 14'd100; req_intake = {4{v}}; req = 4'b1111; rst_n = 1'b0;
    idle(3);
    chk("reset_outputs", {ack, resp_valid, resp_id, resp_up, resp_low, resp_err,
                          eng_give_valid, eng_intake, eng_restart, busy}, 64'd0);
    chk("reset_no_ack_logged", ack_log.size(), 0);
    req = 4'b0000; rst_n = 1'b1;
    idle(3);

    // All four requesting back-to-back; engine holds done long enough to test stale-level rejection.
    ack_log.delete(); resp_log.delete();
    eng_hold = 8; eng_lat = 20; req = 4'b1111;
    wait_resp(4, 400, "multi_resp");
    idle(12);
    chk("multi_ack_count", ack_log.size(), 4);
`ifdef PRIME_QUERY_CACHE_EN
    cached_lat = 2;
`else
    cached_lat = 23;
`endif
    for (int k = 0; k < 4; k++) begin
      chk_resp($sformatf("multi%0d", k), k, k, 101, 97, 0, (k == 0) ? 23 : cached_lat);
      if (k < 3 && resp_log.size() > k && ack_log.size() > k + 1)
        chk($sformatf("multi%0d_next_ack", k), ack_log[k+1].cyc, resp_log[k].cyc + 1);
    end
    eng_hold = 3;

    // Move pointer to 2, then requesters 0 and 3 compete.
    run_one(4'b0010, 200, 10);
    chk_resp("ptr_setup", 0, 1, 211, 199, 0, 13);
    ack_log.delete(); resp_log.delete();
    req = 4'b1001;
    wait_resp(2, 300, "ptr_resp");
    idle(10);
    if (ack_log.size() >= 2 && resp_log.size() >= 2) begin
      chk("ptr_first_ack", ack_log[0].idx, 3);
      chk("ptr_second_ack", ack_log[1].idx, 0);
      chk("ptr_first_id", resp_log[0].id, 3);
      chk("ptr_second_id", resp_log[1].id, 0);
    end

    for (int i = 0; i < 8; i++) begin
      run_one(vecs[i].req, vecs[i].intake, vecs[i].lat);
      chk_resp($sformatf("vec%0d", i), 0, vecs[i].id, vecs[i].up, vecs[i].low,
               vecs[i].err, vecs[i].latency);
      chk($sformatf("vec%0d_gives", i), n_give - g0, vecs[i].gives);
    end

    // Silent engine: timeout aborts, restarts the engine and drops any cached result.
    eng_mute = 1'b1;
    run_one(4'b0001, 10, 20);
    chk_resp("tmo", 0, 0, 0, 0, 1, 53);
    chk("tmo_restarts", n_rst - r0, 1);
    chk("tmo_gives", n_give - g0, 1);
    eng_mute = 1'b0;
    run_one(4'b0100, 50, 5);
    chk_resp("post_tmo", 0, 2, 53, 47, 0, 8);
    chk("post_tmo_gives", n_give - g0, 1);

`ifdef PRIME_QUERY_CACHE_EN
    run_one(4'b0001, 10, 20);
    chk_resp("cache_fill", 0, 0, 11, 7, 0, 23);
    run_one(4'b0001, 10, 20);
    chk_resp("cache_hit", 0, 0, 11, 7, 0, 2);
    chk("cache_hit_gives", n_give - g0, 0);
`endif

    // Reset while waiting on the engine: no response, quiet outputs, then normal service.
    ack_log.delete(); resp_log.delete();
    v = 14'd100; req_intake = {4{v}}; eng_lat = 20; req = 4'b0001;
    wait_ack(1, 50, "midq_ack");
    idle(8);
    chk("midq_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midq_reset_outputs", {ack, resp_valid, resp_id, resp_up, resp_low, resp_err,
                               eng_give_valid, eng_intake, eng_restart, busy}, 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(40);
    chk("midq_no_resp", resp_log.size(), 0);
    run_one(4'b0010, 3, 5);
    chk_resp("after_midq", 0, 1, 5, 2, 0, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
